lif_sparse_scheduler: RTL and testbench
=======================================

LIF_SPARSE_SCHEDULER -- requirements
Module: lif_sparse_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 16, number of time-multiplexed neurons (power of 2, 2..64).
REQ-002 SHALL have parameter THRESHOLD, default 32, 8-bit spike threshold.
REQ-003 SHALL have parameter DECAY_SHIFT, default 1, right-shift applied to state per step (decay 0.5).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port cur_valid  input  1  input-current write request.
REQ-007 SHALL have port cur_ready  output  1  high only in IDLE.
REQ-008 SHALL have port cur_idx  input  log2(N_NEURONS)  target neuron of current write.
REQ-009 SHALL have port cur_data  input  8  unsigned current value.
REQ-010 SHALL have port step_start  input  1  one-cycle pulse beginning a timestep.
REQ-011 SHALL have port busy  output  1  high outside IDLE.
REQ-012 SHALL have port spk_valid  output  1  spike event available.
REQ-013 SHALL have port spk_ready  input  1  consumer accepts spike.
REQ-014 SHALL have port spk_idx  output  log2(N_NEURONS)  index of spiking neuron.
REQ-015 SHALL have port step_done  output  1  one-cycle pulse when timestep completes.

Function
REQ-016 SHALL hold per-neuron 8-bit state[i], 8-bit cur[i], and 1-bit active[i] = (state[i]!=0)|(cur[i]!=0).
REQ-017 SHALL, on cur_valid&cur_ready, set cur[idx] = min(255, cur[idx]+cur_data) (repeated writes accumulate, saturating).
REQ-018 SHALL implement FSM IDLE -> SCAN on step_start; SCAN -> EMIT on spike; EMIT -> SCAN on spk_ready when neurons remain, else DONE; SCAN -> DONE when no neuron remains; DONE -> IDLE after exactly one cycle.
REQ-019 SHALL ignore step_start outside IDLE, and ignore step_start coincident with cur_valid in IDLE except that the write completes first (same cycle write is included in the step).
REQ-020 SHALL update one neuron per SCAN cycle: ns = min(255, cur[i] + (state[i] >> DECAY_SHIFT)); cur[i] <= 0.
REQ-021 SHALL fire when ns >= THRESHOLD: state[i] <= 0, capture spk_idx=i, enter EMIT; otherwise state[i] <= ns.
REQ-022 SHALL hold spk_valid high and spk_idx stable in EMIT until spk_ready; no neuron updates while stalled.
REQ-023 SHALL emit spikes in ascending index order, at most one per neuron per step.
REQ-024 SHALL assert step_done only in DONE; busy=0, spk_valid=0 in IDLE.
REQ-025 SHALL treat a step with no active neurons as IDLE -> SCAN -> DONE (step_done 2 cycles after step_start).

Reset
REQ-026 SHALL, on rst_n=0 at a clock edge in any state (including mid-SCAN/EMIT), clear all state[], cur[], active[], return to IDLE, and drive spk_valid=0, step_done=0, busy=0, spk_idx=0, cur_ready=1 next cycle.

Configuration
REQ-027 SHALL, with LIF_SCHED_SPARSE_EN defined, select next neuron as lowest-indexed set active[] bit above the current index (priority encoder), skipping inactive neurons in zero cycles.
REQ-028 SHALL, without LIF_SCHED_SPARSE_EN, visit every index 0..N_NEURONS-1 sequentially, one cycle each.
REQ-029 SHALL produce identical spike sequences and final state[] in both builds; only cycle counts differ.

Structure
REQ-030 SHALL place FSM state enum, saturating-add width constants and default THRESHOLD/DECAY_SHIFT in shared package lif_pkg.
REQ-031 SHALL implement the per-neuron update (REQ-020/021) in sub-module lif_update_unit (combinational, one instance).
REQ-032 SHALL implement the sparse next-index priority encoder inside this module under the macro guard.

Verification
REQ-033 SHALL cover: cur[3]=40, step -> spk_idx=3 once, state[3]=0 after step; sparse build step_done 3 cycles after step_start with spk_ready tied 1.
REQ-034 SHALL cover: cur[5]=20, step; no input, step -> no spikes, state[5]=20 then 10.
REQ-035 SHALL cover: cur[2]=200 twice -> cur saturates 255; step -> spike on 2.
REQ-036 SHALL cover: cur[1]=cur[9]=50, spk_ready low 5 cycles -> spk_valid/spk_idx=1 held, then idx 9, step_done after both.
REQ-037 SHALL cover: rst_n low during EMIT -> spk_valid=0 next cycle, all state zero, IDLE.
REQ-038 SHALL cover: all-zero step in dense build -> step_done at N_NEURONS+1 cycles after step_start; sparse build at 2 cycles.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF sparse scheduler.
//   lif_state_e      : scheduler FSM states
//   DATA_W / SUM_W   : neuron datapath width and the carry-inclusive width used by saturating adds
//   DEF_THRESHOLD    : default spike threshold
//   DEF_DECAY_SHIFT  : default per-step decay right-shift
//   sat_add()        : 8-bit unsigned add clamped at 255
package lif_pkg;
  localparam int DATA_W = 8;
  localparam int SUM_W  = DATA_W + 1;
  localparam logic [DATA_W-1:0] SAT_MAX = '1;
  localparam int DEF_THRESHOLD   = 32;
  localparam int DEF_DECAY_SHIFT = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_EMIT, ST_DONE} lif_state_e;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? SAT_MAX : s[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/lif_update_unit.sv
// Combinational leaky-integrate-and-fire update for one neuron.
//   state     : current membrane state
//   cur       : accumulated input current for this step
//   state_nxt : state to write back (0 after a spike)
//   fire      : decayed+integrated state reached THRESHOLD
module lif_update_unit import lif_pkg::*; #(
  parameter int THRESHOLD   = DEF_THRESHOLD,
  parameter int DECAY_SHIFT = DEF_DECAY_SHIFT
) (
  input  logic [DATA_W-1:0] state,
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] state_nxt,
  output logic              fire
);
  localparam logic [DATA_W-1:0] THR = DATA_W'(THRESHOLD);

  logic [DATA_W-1:0] ns;

  always_comb begin
    ns        = sat_add(cur, state >> DECAY_SHIFT);
    fire      = (ns >= THR);
    state_nxt = fire ? '0 : ns;
  end
endmodule

// File: rtl/lif_sparse_scheduler.sv
// Time-multiplexed LIF neuron scheduler. Currents are accumulated while IDLE;
// a step_start pulse walks the neurons in ascending order, updating one per
// SCAN cycle and stalling in EMIT for each spike until the consumer accepts it.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   cur_valid/cur_ready/idx/data    : saturating current write (IDLE only)
//   step_start                      : begin a timestep (IDLE only)
//   busy, step_done                 : not IDLE / one-cycle completion pulse
//   spk_valid/spk_ready/spk_idx     : spike event handshake
// Build option: define LIF_SCHED_SPARSE_EN to skip inactive neurons with a
// priority encoder; otherwise every index is visited one cycle each.
module lif_sparse_scheduler import lif_pkg::*; #(
  parameter int N_NEURONS   = 16,
  parameter int THRESHOLD   = DEF_THRESHOLD,
  parameter int DECAY_SHIFT = DEF_DECAY_SHIFT,
  localparam int IW = $clog2(N_NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cur_valid,
  output logic          cur_ready,
  input  logic [IW-1:0] cur_idx,
  input  logic [7:0]    cur_data,
  input  logic          step_start,
  output logic          busy,
  output logic          spk_valid,
  input  logic          spk_ready,
  output logic [IW-1:0] spk_idx,
  output logic          step_done
);
  lif_state_e st, st_nxt;

  logic [N_NEURONS-1:0][DATA_W-1:0] state_q, cur_q;
  logic [IW-1:0] ptr;        // next index eligible for update
  logic [IW-1:0] spk_idx_q;
  logic [IW-1:0] cand_idx;   // neuron updated this SCAN cycle
  logic          cand_found;
  logic [IW-1:0] base;       // index above which "remaining" is judged
  logic          rem;
  logic          upd_en;
  logic [DATA_W-1:0] uu_state;
  logic          uu_fire;

  assign base = (st == ST_EMIT) ? spk_idx_q : cand_idx;

`ifdef LIF_SCHED_SPARSE_EN
  logic [N_NEURONS-1:0] active;

  always_comb begin
    for (int i = 0; i < N_NEURONS; i++)
      active[i] = (state_q[i] != '0) || (cur_q[i] != '0);
  end

  // Lowest active index at or above ptr; descending loop lets the lowest win.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = N_NEURONS-1; i >= 0; i--) begin
      if (active[i] && (i >= int'(ptr))) begin
        cand_found = 1'b1;
        cand_idx   = IW'(i);
      end
    end
  end

  // Neurons above base are untouched this step, so their current active bit is valid.
  always_comb begin
    rem = 1'b0;
    for (int i = 0; i < N_NEURONS; i++)
      if (active[i] && (i > int'(base))) rem = 1'b1;
  end
`else
  assign cand_found = 1'b1;
  assign cand_idx   = ptr;
  assign rem        = (base != IW'(N_NEURONS-1));
`endif

  lif_update_unit #(.THRESHOLD(THRESHOLD), .DECAY_SHIFT(DECAY_SHIFT)) u_upd (
    .state     (state_q[cand_idx]),
    .cur       (cur_q[cand_idx]),
    .state_nxt (uu_state),
    .fire      (uu_fire)
  );

  always_comb begin
    st_nxt = st;
    upd_en = 1'b0;
    case (st)
      ST_IDLE: if (step_start) st_nxt = ST_SCAN;
      ST_SCAN: begin
        if (!cand_found) st_nxt = ST_DONE;
        else begin
          upd_en = 1'b1;
          if (uu_fire)  st_nxt = ST_EMIT;
          else if (rem) st_nxt = ST_SCAN;
          else          st_nxt = ST_DONE;
        end
      end
      ST_EMIT: if (spk_ready) st_nxt = rem ? ST_SCAN : ST_DONE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      state_q   <= '0;
      cur_q     <= '0;
      ptr       <= '0;
      spk_idx_q <= '0;
    end else begin
      st <= st_nxt;
      // Writes only land in IDLE and updates only in SCAN, so they never collide.
      if (cur_valid && cur_ready)
        cur_q[cur_idx] <= sat_add(cur_q[cur_idx], cur_data);
      if (st == ST_IDLE && step_start)
        ptr <= '0;
      if (upd_en) begin
        state_q[cand_idx] <= uu_state;
        cur_q[cand_idx]   <= '0;
        ptr               <= cand_idx + IW'(1);  // wrap at top is harmless: FSM leaves SCAN
        if (uu_fire) spk_idx_q <= cand_idx;
      end
    end
  end

  assign cur_ready = (st == ST_IDLE);
  assign busy      = (st != ST_IDLE);
  assign spk_valid = (st == ST_EMIT);
  assign step_done = (st == ST_DONE);
  assign spk_idx   = spk_idx_q;
endmodule

// File: tb/tb_lif_sparse_scheduler.sv
module tb_lif_sparse_scheduler;
  localparam int N  = 16;
  localparam int IW = $clog2(N);
  localparam int BUDGET = 4*N + 20;
`ifdef LIF_SCHED_SPARSE_EN
  localparam int LAT_ZERO = 2;
  localparam int LAT_ONE3 = 3;
`else
  localparam int LAT_ZERO = N + 1;
  localparam int LAT_ONE3 = N + 2;
`endif

  logic clk, rst_n;
  logic cur_valid, cur_ready, step_start, busy, spk_valid, spk_ready, step_done;
  logic [IW-1:0] cur_idx, spk_idx;
  logic [7:0] cur_data;

  int checks = 0;
  int failures = 0;

  lif_sparse_scheduler #(.N_NEURONS(N), .THRESHOLD(32), .DECAY_SHIFT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cur_valid(cur_valid), .cur_ready(cur_ready),
    .cur_idx(cur_idx), .cur_data(cur_data), .step_start(step_start), .busy(busy),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx), .step_done(step_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int do_wr; int widx; int wdata;
    int exp_nspk; int exp_spk0; int chk_idx; int exp_state;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic write_cur(input int idx, input int data);
    cur_valid = 1'b1; cur_idx = IW'(idx); cur_data = 8'(data);
    @(negedge clk);
    cur_valid = 1'b0;
  endtask

  task automatic run_step(output int nspk, output int s0, output int s1, output int dcyc);
    nspk = 0; s0 = -1; s1 = -1; dcyc = -1;
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      if (spk_valid && spk_ready) begin
        if (nspk == 0) s0 = int'(spk_idx); else if (nspk == 1) s1 = int'(spk_idx);
        nspk++;
      end
      if (step_done) begin dcyc = c; break; end
      @(negedge clk);
    end
    @(negedge clk);  // let DONE return to IDLE
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic int all_zero();
    for (int i = 0; i < N; i++)
      if (dut.state_q[i] != 8'd0 || dut.cur_q[i] != 8'd0) return 0;
    return 1;
  endfunction

  initial begin
    int nspk, s0, s1, dcyc, seen;
    rst_n = 1'b0; cur_valid = 1'b0; cur_idx = '0; cur_data = '0;
    step_start = 1'b0; spk_ready = 1'b1;

    // Running sequence on accumulated state: THRESHOLD 32, decay by half.
    vecs[0] = '{1, 5,  20, 0, -1, 5, 20};
    vecs[1] = '{0, 0,   0, 0, -1, 5, 10};
    vecs[2] = '{1, 3,  40, 1,  3, 3,  0};
    vecs[3] = '{0, 0,   0, 0, -1, 5,  2};
    vecs[4] = '{1, 7,  31, 0, -1, 7, 31};
    vecs[5] = '{1, 7,  17, 1,  7, 7,  0};   // 17 + 31>>1 = 32 exactly
    vecs[6] = '{1, 0,  32, 1,  0, 0,  0};
    vecs[7] = '{1, 15, 255, 1, 15, 15, 0};
    vecs[8] = '{1, 4,  31, 0, -1, 4, 31};
    vecs[9] = '{0, 0,   0, 0, -1, 4, 15};

    repeat (2) @(negedge clk);
    check("rst_cur_ready", int'(cur_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_spk_valid", int'(spk_valid), 0);
    check("rst_step_done", int'(step_done), 0);
    check("rst_spk_idx", int'(spk_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero step latency
    run_step(nspk, s0, s1, dcyc);
    check("zero_step_latency", dcyc, LAT_ZERO);
    check("zero_step_nspk", nspk, 0);

    // Single spike on 3 with spk_ready tied high
    write_cur(3, 40);
    run_step(nspk, s0, s1, dcyc);
    check("one3_latency", dcyc, LAT_ONE3);
    check("one3_nspk", nspk, 1);
    check("one3_idx", s0, 3);
    check("one3_state", int'(dut.state_q[3]), 0);

    do_reset();
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].do_wr != 0) write_cur(vecs[v].widx, vecs[v].wdata);
      run_step(nspk, s0, s1, dcyc);
      check($sformatf("vec%0d_done", v), int'(dcyc > 0), 1);
      check($sformatf("vec%0d_nspk", v), nspk, vecs[v].exp_nspk);
      if (vecs[v].exp_nspk > 0) check($sformatf("vec%0d_spk", v), s0, vecs[v].exp_spk0);
      check($sformatf("vec%0d_state", v), int'(dut.state_q[vecs[v].chk_idx]), vecs[v].exp_state);
    end

    // Saturating accumulate
    do_reset();
    write_cur(2, 200);
    write_cur(2, 200);
    check("sat_cur2", int'(dut.cur_q[2]), 255);
    run_step(nspk, s0, s1, dcyc);
    check("sat_nspk", nspk, 1);
    check("sat_spk", s0, 2);

    // Backpressure: two spikes, consumer stalls the first for 5 cycles
    do_reset();
    write_cur(1, 50);
    write_cur(9, 50);
    spk_ready = 1'b0;
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    seen = 0;
    for (int c = 0; c < BUDGET && !spk_valid; c++) @(negedge clk);
    check("bp_first_valid", int'(spk_valid), 1);
    check("bp_first_idx", int'(spk_idx), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", c), int'({spk_valid, busy, spk_idx == IW'(1)}), 7);
    end
    spk_ready = 1'b1;
    nspk = 0; s0 = -1; dcyc = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (spk_valid) begin s0 = int'(spk_idx); nspk++; end
      if (step_done) begin dcyc = c; break; end
    end
    check("bp_second_nspk", nspk, 1);
    check("bp_second_idx", s0, 9);
    check("bp_done_seen", int'(dcyc > 0), 1);
    @(negedge clk);
    check("bp_states_zero", all_zero(), 1);

    // Reset while stalled in EMIT
    do_reset();
    write_cur(6, 100);
    write_cur(10, 7);
    spk_ready = 1'b0;
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    for (int c = 0; c < BUDGET && !spk_valid; c++) @(negedge clk);
    check("emit_rst_reached", int'(spk_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("emit_rst_valid", int'(spk_valid), 0);
    check("emit_rst_busy", int'(busy), 0);
    check("emit_rst_ready", int'(cur_ready), 1);
    check("emit_rst_idx", int'(spk_idx), 0);
    check("emit_rst_done", int'(step_done), 0);
    check("emit_rst_zero", all_zero(), 1);
    rst_n = 1'b1;
    spk_ready = 1'b1;
    @(negedge clk);
    run_step(nspk, s0, s1, dcyc);
    check("post_rst_latency", dcyc, LAT_ZERO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
